// File: rtl/key_debounce.sv
// key_debounce
//   Conditions raw active-low pushbuttons before they reach the lock FSM.
//   Each key channel has a 2-flop synchronizer, a counter-based debouncer
//   and a press one-shot. A physical press gives one single-cycle strobe
//   plus a clean debounced level.
//
// Ports
//   Clock    in   1         system clock
//   Reset    in   1         asynchronous reset, active-low
//   KeyN     in   NUM_KEYS  raw pushbutton levels, active-low, asynchronous
//   Pulse    out  NUM_KEYS  one-cycle press strobe per key, active-high
//   Pressed  out  NUM_KEYS  debounced key level, active-high (1 = held)
//
// Parameters
//   NUM_KEYS         number of independent key channels
//   DEBOUNCE_CYCLES  cycles the synced input must stay stable to be accepted (>= 1)
//   CNT_W            debounce counter width, 2**CNT_W >= DEBOUNCE_CYCLES
module key_debounce #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NUM_KEYS-1:0] KeyN,
  output logic [NUM_KEYS-1:0] Pulse,
  output logic [NUM_KEYS-1:0] Pressed
);

  // Terminal count: the run of differing samples is accepted on the edge
  // where the counter already holds DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi = gi + 1) begin : g_key
      logic             sync1_reg;
      logic             sync2_reg;
      logic             stable_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             pulse_reg;
      logic             pressed_reg;

      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          sync1_reg   <= 1'b1;
          sync2_reg   <= 1'b1;
          stable_reg  <= 1'b1;
          cnt_reg     <= '0;
          pulse_reg   <= 1'b0;
          pressed_reg <= 1'b0;
        end else begin
          sync1_reg <= KeyN[gi];
          sync2_reg <= sync1_reg;
          pulse_reg <= 1'b0;
          if (sync2_reg == stable_reg) begin
            // Any return to the accepted level restarts the qualification run.
            cnt_reg <= '0;
          end else if (cnt_reg == TERM) begin
            stable_reg  <= sync2_reg;
            // Pressed is updated on the same edge as the accepted level so it
            // and the strobe rise together; release (0->1) gives no strobe.
            pressed_reg <= ~sync2_reg;
            pulse_reg   <= ~sync2_reg;
            cnt_reg     <= '0;
          end else begin
            cnt_reg <= cnt_reg + ONE;
          end
        end
      end

      assign Pulse[gi]   = pulse_reg;
      assign Pressed[gi] = pressed_reg;
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

  localparam int NK = 2;
  localparam int DC = 4;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] keyn;
  logic [NK-1:0] pulse;
  logic [NK-1:0] pressed;

  int n_vec = 0;
  int n_err = 0;

  key_debounce #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .Clock  (clk),
    .Reset  (rst_n),
    .KeyN   (keyn),
    .Pulse  (pulse),
    .Pressed(pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [NK-1:0] keyn;
    logic [NK-1:0] exp_pulse;
    logic [NK-1:0] exp_pressed;
  } vec_t;

  vec_t vecs[$];

  // Segment of `len` cycles with constant inputs. A clean level change seen
  // at the start of the segment is accepted on its 6th cycle (DC+2).
  function automatic void add_seg(input logic rst, input logic [NK-1:0] k, input int len,
                                  input logic [NK-1:0] pul, input logic [NK-1:0] pre,
                                  input logic [NK-1:0] post);
    vec_t v;
    for (int j = 1; j <= len; j++) begin
      v.rst         = rst;
      v.keyn        = k;
      v.exp_pulse   = (j == DC + 2) ? pul : '0;
      v.exp_pressed = (j >= DC + 2) ? post : pre;
      vecs.push_back(v);
    end
  endfunction

  task automatic check(input string name, input logic [NK-1:0] ep, input logic [NK-1:0] epr);
    n_vec++;
    if (pulse !== ep || pressed !== epr) begin
      n_err++;
      $display("FAIL %s: pulse=%b pressed=%b, required pulse=%b pressed=%b",
               name, pulse, pressed, ep, epr);
    end
  endtask

  // Drive one cycle: inputs change at the falling edge, outputs sampled 2 ns
  // after the following rising edge.
  task automatic apply(input logic rst, input logic [NK-1:0] k);
    @(negedge clk);
    rst_n = rst;
    keyn  = k;
    @(posedge clk);
    #2;
  endtask

  // Reference model: a key's accepted level flips once its synced input
  // (raw input two edges old) has disagreed with it on DC consecutive edges.
  logic [NK-1:0] m_pipe0, m_pipe1, m_level, m_pulse, m_pressed;
  int            m_run[NK];

  function automatic void model_reset();
    m_pipe0   = '1;
    m_pipe1   = '1;
    m_level   = '1;
    m_pulse   = '0;
    m_pressed = '0;
    for (int i = 0; i < NK; i++) m_run[i] = 0;
  endfunction

  function automatic void model_step(input logic [NK-1:0] k);
    m_pulse = '0;
    for (int i = 0; i < NK; i++) begin
      if (m_pipe1[i] != m_level[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DC) begin
          m_level[i] = m_pipe1[i];
          m_pulse[i] = (m_level[i] == 1'b0);
          m_run[i]   = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_pipe1   = m_pipe0;
    m_pipe0   = k;
    m_pressed = ~m_level;
  endfunction

  initial begin
    int wait_cnt;
    logic [NK-1:0] k;

    rst_n = 1'b0;
    keyn  = '1;

    // ---- table-driven directed vectors ----
    add_seg(0, 2'b11, 3, 2'b00, 2'b00, 2'b00);   // reset
    add_seg(1, 2'b11, 2, 2'b00, 2'b00, 2'b00);
    add_seg(1, 2'b10, 20, 2'b01, 2'b00, 2'b01);  // key0 press held
    add_seg(1, 2'b11, 10, 2'b00, 2'b01, 2'b00);  // key0 release, no pulse
    add_seg(1, 2'b01, 2, 2'b00, 2'b00, 2'b00);   // key1 bounce
    add_seg(1, 2'b11, 2, 2'b00, 2'b00, 2'b00);
    add_seg(1, 2'b01, 2, 2'b00, 2'b00, 2'b00);
    add_seg(1, 2'b11, 2, 2'b00, 2'b00, 2'b00);
    add_seg(1, 2'b01, 10, 2'b10, 2'b00, 2'b10);  // key1 final hold
    add_seg(1, 2'b11, 8, 2'b00, 2'b10, 2'b00);
    add_seg(1, 2'b00, 8, 2'b11, 2'b00, 2'b11);   // both keys together
    add_seg(1, 2'b11, 8, 2'b00, 2'b11, 2'b00);
    add_seg(1, 2'b10, 3, 2'b00, 2'b00, 2'b00);   // run of DC-1: rejected
    add_seg(1, 2'b11, 6, 2'b00, 2'b00, 2'b00);
    add_seg(1, 2'b10, 8, 2'b01, 2'b00, 2'b01);   // re-press key0
    add_seg(1, 2'b11, 8, 2'b00, 2'b01, 2'b00);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].keyn);
      check($sformatf("table[%0d]", i), vecs[i].exp_pulse, vecs[i].exp_pressed);
    end

    // ---- exact-DC run is accepted ----
    for (int j = 1; j <= 8; j++) begin
      apply(1'b1, (j <= DC) ? 2'b10 : 2'b11);
      check("exact_run", (j == DC + 2) ? 2'b01 : 2'b00, (j >= DC + 2) ? 2'b01 : 2'b00);
    end
    for (int j = 1; j <= 8; j++) apply(1'b1, 2'b11);
    check("exact_run_rel", 2'b00, 2'b00);

    // ---- reset mid-qualification with key held ----
    for (int j = 1; j <= 4; j++) begin
      apply(1'b1, 2'b10);
      check("pre_reset", 2'b00, 2'b00);
    end
    for (int j = 1; j <= 3; j++) begin
      apply(1'b0, 2'b10);
      check("in_reset", 2'b00, 2'b00);
    end
    wait_cnt = 0;
    do begin
      apply(1'b1, 2'b10);
      wait_cnt++;
    end while (pulse[0] !== 1'b1 && wait_cnt < 20);
    n_vec++;
    if (wait_cnt != DC + 2) begin
      n_err++;
      $display("FAIL requalify_latency: pulse after %0d edges, required %0d", wait_cnt, DC + 2);
    end
    check("requalify_pulse", 2'b01, 2'b01);
    for (int j = 1; j <= 10; j++) begin
      apply(1'b1, 2'b10);
      check("requalify_hold", 2'b00, 2'b01);
    end
    for (int j = 1; j <= 8; j++) apply(1'b1, 2'b11);
    check("requalify_rel", 2'b00, 2'b00);

    // ---- randomized stimulus against reference model ----
    apply(1'b0, 2'b11);
    model_reset();
    check("rand_reset", m_pulse, m_pressed);
    k = '1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 5) == 0) k[i] = ~k[i];
      keyn  = k;
      rst_n = ($urandom_range(0, 199) != 0);
      if (!rst_n) model_reset();
      @(posedge clk);
      if (rst_n) model_step(k);
      #2;
      check($sformatf("rand[%0d]", c), m_pulse, m_pressed);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
